// File: rtl/sdram_tester_if.sv
// SDRAM strobe bus between the tester (master) and the memory (slave).
interface sdram_tester_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_din;
  logic [DATA_W-1:0] sdram_dout;
  logic              sdram_we;
  logic              sdram_oe;

  modport master (output sdram_addr, sdram_din, sdram_we, sdram_oe, input sdram_dout);
  modport slave  (input sdram_addr, sdram_din, sdram_we, sdram_oe, output sdram_dout);
endinterface

// File: rtl/sdram_tester.sv
// SDRAM pattern tester: writes pattern(addr) over [addr_lo, addr_hi], reads it back and counts mismatches.
// Fixed timing: each strobe is held ACC_CYCLES cycles, then GAP_CYCLES idle; there is no backpressure.
module sdram_tester #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              F14M,
  input  logic              RESET_n,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  sdram_tester_if.master    sdram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              led,
  output logic [15:0]       err_count,
  output logic [15:0]       run_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP, DONE} state_t;

  localparam logic [7:0] ACC_LAST = 8'(ACC_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit         NO_GAP   = (GAP_CYCLES == 0);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_q, cur_d, lo_q, lo_d, hi_q, hi_d, fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] seed_q, seed_d, fail_data_q, fail_data_d, pat;
  logic [1:0]        mode_q, mode_d;
  logic              loop_q, loop_d, pass_q, pass_d;
  logic [15:0]       err_q, err_d, run_q, run_d;
  logic              acc_end, wstep, rstep, at_hi;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0]   rot;
    logic [2*DATA_W-1:0] dbl;
    rot = a % ADDR_W'(DATA_W);
    // Upper half of the doubled seed shifted left is the left rotation.
    dbl = {s, s} << rot;
    case (m)
      2'd0:    pattern = s;
      2'd1:    pattern = DATA_W'(a) ^ s;
      2'd2:    pattern = ~DATA_W'(a);
      default: pattern = dbl[2*DATA_W-1:DATA_W];
    endcase
  endfunction

  assign pat     = pattern(mode_q, seed_q, cur_q);
  assign at_hi   = (cur_q == hi_q);
  assign acc_end = (cnt_q == ACC_LAST);
  // With no gap, the boundary decision is taken on the last strobe cycle itself.
  assign wstep   = (state_q == WGAP && cnt_q == GAP_LAST) || (NO_GAP && state_q == WRITE && acc_end);
  assign rstep   = (state_q == RGAP && cnt_q == GAP_LAST) || (NO_GAP && state_q == READ && acc_end);

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      seed_q      <= '0;
      mode_q      <= '0;
      loop_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      run_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      loop_q      <= loop_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      run_q       <= run_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    loop_d      = loop_q;
    pass_d      = pass_q;
    err_d       = err_q;
    run_d       = run_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d      = mode;
          seed_d      = seed;
          lo_d        = addr_lo;
          hi_d        = addr_hi;
          loop_d      = loop;
          cur_d       = addr_lo;
          cnt_d       = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = (addr_hi < addr_lo);
          state_d     = (addr_hi < addr_lo) ? DONE : WRITE;
        end
      end
      WRITE: begin
        cnt_d = acc_end ? 8'd0 : cnt_q + 8'd1;
        if (acc_end) state_d = WGAP;
      end
      READ: begin
        cnt_d = acc_end ? 8'd0 : cnt_q + 8'd1;
        if (acc_end) begin
          state_d = RGAP;
          if (sdram.sdram_dout != pat) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) begin
              fail_addr_d = cur_q;
              fail_data_d = sdram.sdram_dout;
            end
          end
        end
      end
      WGAP, RGAP: cnt_d = cnt_q + 8'd1;
      default:    state_d = IDLE;
    endcase

    if (wstep) begin
      cnt_d = '0;
      if (abort) begin
        state_d = DONE;
        pass_d  = 1'b0;
      end else if (at_hi) begin
        cur_d   = lo_q;
        state_d = READ;
      end else begin
        cur_d   = cur_q + ADDR_W'(1);
        state_d = WRITE;
      end
    end

    if (rstep) begin
      cnt_d = '0;
      if (at_hi) run_d = run_q + 16'd1;
      if (abort) begin
        state_d = DONE;
        pass_d  = 1'b0;
      end else if (!at_hi) begin
        cur_d   = cur_q + ADDR_W'(1);
        state_d = READ;
      end else if (loop_q) begin
        cur_d   = lo_q;
        state_d = WRITE;
      end else begin
        state_d = DONE;
        pass_d  = (err_d == 16'd0);
      end
    end
  end

  always_comb begin
    sdram.sdram_we   = (state_q == WRITE);
    sdram.sdram_oe   = (state_q == READ);
    sdram.sdram_addr = (state_q == WRITE || state_q == READ) ? cur_q : '0;
    sdram.sdram_din  = (state_q == WRITE) ? pat : '0;
    busy             = (state_q == WRITE) || (state_q == WGAP) || (state_q == READ) || (state_q == RGAP);
    done             = (state_q == DONE);
    pass             = pass_q;
    led              = busy | (done & ~pass_q);
    err_count        = err_q;
    run_count        = run_q;
    fail_addr        = fail_addr_q;
    fail_data        = fail_data_q;
  end
endmodule

// File: tb/tb_sdram_tester.sv
// Bench for sdram_tester: behavioural RAM with optional read corruption, strobe monitor, directed and random runs.
module tb_sdram_tester;
  localparam int AW = 23;
  localparam int DW = 8;
  localparam int ACC = 4;
  localparam int GAP = 2;
  localparam int BUDGET = 3000;

  logic F14M = 1'b0;
  logic RESET_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic [1:0] mode = '0;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] addr_lo = '0, addr_hi = '0;
  logic busy, done, pass, led;
  logic [15:0] err_count, run_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  sdram_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_tester #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC), .GAP_CYCLES(GAP)) dut (
    .F14M(F14M), .RESET_n(RESET_n), .start(start), .abort(abort), .loop(loop),
    .mode(mode), .seed(seed), .addr_lo(addr_lo), .addr_hi(addr_hi), .sdram(bus),
    .busy(busy), .done(done), .pass(pass), .led(led), .err_count(err_count),
    .run_count(run_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 F14M = ~F14M;

  int tests_run = 0;
  int fails = 0;

  // RAM model and strobe monitor, sampled mid-cycle
  logic [DW-1:0] mem [int];
  bit corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [AW-1:0] wr_a[$], rd_a[$];
  logic [DW-1:0] wr_d[$];
  int wr_w[$], rd_w[$];
  bit prev_we = 1'b0, prev_oe = 1'b0;
  int overlap = 0, touched0 = 0, mon_n;

  always @(negedge F14M) begin
    if (bus.sdram_we && bus.sdram_oe) overlap++;
    if ((bus.sdram_we || bus.sdram_oe) && bus.sdram_addr == '0) touched0++;
    if (bus.sdram_we) begin
      if (!prev_we) begin
        wr_a.push_back(bus.sdram_addr);
        wr_d.push_back(bus.sdram_din);
        wr_w.push_back(0);
      end
      mon_n = wr_w.size();
      wr_w[mon_n-1] = wr_w[mon_n-1] + 1;
      mem[int'(bus.sdram_addr)] = bus.sdram_din;
    end
    if (bus.sdram_oe) begin
      if (!prev_oe) begin
        rd_a.push_back(bus.sdram_addr);
        rd_w.push_back(0);
      end
      mon_n = rd_w.size();
      rd_w[mon_n-1] = rd_w[mon_n-1] + 1;
      if (corrupt_en && bus.sdram_addr == corrupt_addr) bus.sdram_dout = '0;
      else if (mem.exists(int'(bus.sdram_addr))) bus.sdram_dout = mem[int'(bus.sdram_addr)];
      else bus.sdram_dout = '0;
    end else begin
      bus.sdram_dout = DW'($urandom);
    end
    prev_we = bus.sdram_we;
    prev_oe = bus.sdram_oe;
  end

  function automatic logic [DW-1:0] pat_ref(int m, int s, int a);
    int p, r, v;
    p = a % 256;
    r = a % 8;
    case (m)
      0: v = s;
      1: v = p ^ s;
      2: v = 255 - p;
      default: v = ((s << r) | (s >> (8 - r))) & 255;
    endcase
    return DW'(v);
  endfunction

  task automatic clear_mon();
    wr_a.delete(); wr_d.delete(); wr_w.delete(); rd_a.delete(); rd_w.delete();
    overlap = 0;
    touched0 = 0;
  endtask

  task automatic start_run(input int lo, input int hi, input int m, input int s, input int lp);
    @(posedge F14M); #1;
    addr_lo = AW'(lo); addr_hi = AW'(hi); mode = 2'(m); seed = DW'(s); loop = lp[0];
    start = 1'b1;
    @(posedge F14M); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit timeout);
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(posedge F14M); #1;
      cyc++;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    repeat (3) @(posedge F14M);
    #1;
    tests_run++; if ({busy, done, pass, led} !== 4'b0) begin fails++; $display("FAIL reset_status got=%b want=0000", {busy, done, pass, led}); end
    tests_run++; if ({err_count, run_count} !== 32'h0) begin fails++; $display("FAIL reset_counters got=%h want=0", {err_count, run_count}); end
    tests_run++; if (fail_addr !== '0 || fail_data !== '0) begin fails++; $display("FAIL reset_fail got=%h/%h want=0/0", fail_addr, fail_data); end
    tests_run++; if ({bus.sdram_we, bus.sdram_oe} !== 2'b00 || bus.sdram_addr !== '0 || bus.sdram_din !== '0) begin fails++; $display("FAIL reset_bus got we=%b oe=%b a=%h d=%h want 0", bus.sdram_we, bus.sdram_oe, bus.sdram_addr, bus.sdram_din); end
    RESET_n = 1'b1;
    repeat (2) @(posedge F14M);
  endtask

  task automatic test_basic();
    int cyc, bad;
    bit to;
    clear_mon();
    corrupt_en = 1'b0;
    start_run(32'h3800, 32'h3803, 0, 8'h41, 0);
    wait_done(cyc, to);
    tests_run++; if (to) begin fails++; $display("FAIL basic_timeout got cycles=%0d want done", cyc); end
    tests_run++; if (wr_a.size() != 4 || rd_a.size() != 4) begin fails++; $display("FAIL basic_counts got wr=%0d rd=%0d want 4/4", wr_a.size(), rd_a.size()); end
    bad = 0;
    for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] !== AW'(32'h3800 + i) || wr_d[i] !== 8'h41 || wr_w[i] != 4) bad++;
    for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== AW'(32'h3800 + i) || rd_w[i] != 4) bad++;
    tests_run++; if (bad != 0) begin fails++; $display("FAIL basic_strobes got bad=%0d want 0", bad); end
    tests_run++; if ({done, pass, busy, led} !== 4'b1100) begin fails++; $display("FAIL basic_status got dpbl=%b want 1100", {done, pass, busy, led}); end
    tests_run++; if (err_count !== 16'd0 || run_count !== 16'd1) begin fails++; $display("FAIL basic_counts2 got err=%0d run=%0d want 0/1", err_count, run_count); end
    tests_run++; if (cyc != 8 * (ACC + GAP)) begin fails++; $display("FAIL basic_cycles got=%0d want=%0d", cyc, 8 * (ACC + GAP)); end
  endtask

  task automatic test_corrupt();
    int cyc;
    bit to;
    logic [15:0] base;
    base = run_count;
    clear_mon();
    corrupt_en = 1'b1;
    corrupt_addr = AW'(32'h3802);
    start_run(32'h3800, 32'h3803, 0, 8'h41, 0);
    wait_done(cyc, to);
    corrupt_en = 1'b0;
    tests_run++; if (to || pass !== 1'b0 || led !== 1'b1) begin fails++; $display("FAIL corrupt_status got to=%0b pass=%b led=%b want 0/0/1", to, pass, led); end
    tests_run++; if (err_count !== 16'd1) begin fails++; $display("FAIL corrupt_err got=%0d want=1", err_count); end
    tests_run++; if (fail_addr !== AW'(32'h3802) || fail_data !== 8'h00) begin fails++; $display("FAIL corrupt_fail got=%h/%h want=3802/00", fail_addr, fail_data); end
    tests_run++; if (run_count !== base + 16'd1) begin fails++; $display("FAIL corrupt_run got=%0d want=%0d", run_count, base + 16'd1); end
  endtask

  task automatic test_empty_range();
    int cyc;
    bit to;
    clear_mon();
    start_run(32'h10, 32'h0F, 1, 8'h33, 0);
    wait_done(cyc, to);
    tests_run++; if (cyc != 0 || done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL empty_done got cyc=%0d done=%b pass=%b busy=%b want 0/1/1/0", cyc, done, pass, busy); end
    repeat (10) @(posedge F14M);
    #1;
    tests_run++; if (wr_a.size() + rd_a.size() != 0 || led !== 1'b0) begin fails++; $display("FAIL empty_strobes got=%0d led=%b want 0/0", wr_a.size() + rd_a.size(), led); end
  endtask

  task automatic test_top_address();
    int cyc;
    bit to;
    logic [DW-1:0] d0;
    clear_mon();
    start_run(32'h7FFFFF, 32'h7FFFFF, 2, 32'($urandom_range(0, 255)), 0);
    wait_done(cyc, to);
    d0 = (wr_d.size() > 0) ? wr_d[0] : 8'hxx;
    tests_run++; if (to || wr_a.size() != 1 || rd_a.size() != 1) begin fails++; $display("FAIL top_counts got to=%0b wr=%0d rd=%0d want 0/1/1", to, wr_a.size(), rd_a.size()); end
    tests_run++; if (d0 !== 8'h00) begin fails++; $display("FAIL top_data got=%h want=00", d0); end
    tests_run++; if (touched0 != 0 || pass !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL top_end got addr0=%0d pass=%b done=%b want 0/1/1", touched0, pass, done); end
  endtask

  task automatic test_random();
    int cyc, bad, lo, len, m, s, ca, exp_err;
    bit to, c_en;
    logic [15:0] base;
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(1, 5);
      lo = $urandom_range(0, (1 << AW) - 16);
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 255);
      c_en = $urandom_range(0, 1) == 1;
      ca = lo + $urandom_range(0, len - 1);
      exp_err = (c_en && pat_ref(m, s, ca) != 8'h00) ? 1 : 0;
      base = run_count;
      clear_mon();
      corrupt_en = c_en;
      corrupt_addr = AW'(ca);
      start_run(lo, lo + len - 1, m, s, 0);
      wait_done(cyc, to);
      corrupt_en = 1'b0;
      bad = 0;
      for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] !== AW'(lo + i) || wr_d[i] !== pat_ref(m, s, lo + i) || wr_w[i] != ACC) bad++;
      for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== AW'(lo + i) || rd_w[i] != ACC) bad++;
      tests_run++; if (to || cyc != 2 * len * (ACC + GAP)) begin fails++; $display("FAIL rand%0d_cycles got=%0d want=%0d", it, cyc, 2 * len * (ACC + GAP)); end
      tests_run++; if (wr_a.size() != len || rd_a.size() != len || bad != 0 || overlap != 0) begin fails++; $display("FAIL rand%0d_strobes got wr=%0d rd=%0d bad=%0d ovl=%0d want %0d/%0d/0/0", it, wr_a.size(), rd_a.size(), bad, overlap, len, len); end
      tests_run++; if (err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin fails++; $display("FAIL rand%0d_result got err=%0d pass=%b want err=%0d", it, err_count, pass, exp_err); end
      if (exp_err != 0) begin
        tests_run++; if (fail_addr !== AW'(ca) || fail_data !== 8'h00) begin fails++; $display("FAIL rand%0d_fail got=%h/%h want=%h/00", it, fail_addr, fail_data, ca); end
      end
      tests_run++; if (run_count !== base + 16'd1) begin fails++; $display("FAIL rand%0d_run got=%0d want=%0d", it, run_count, base + 16'd1); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, lo, bad;
    bit to;
    lo = 32'h1234;
    clear_mon();
    start_run(lo, lo + 2, 1, 8'hC3, 0);
    repeat (5) @(posedge F14M);
    start_run(0, 0, 0, 8'h00, 0);
    wait_done(cyc, to);
    bad = 0;
    for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] !== AW'(lo + i) || wr_d[i] !== pat_ref(1, 8'hC3, lo + i)) bad++;
    tests_run++; if (to || wr_a.size() != 3 || bad != 0 || touched0 != 0) begin fails++; $display("FAIL busy_start got wr=%0d bad=%0d addr0=%0d want 3/0/0", wr_a.size(), bad, touched0); end
  endtask

  task automatic test_loop_abort();
    int cyc;
    bit to;
    logic [15:0] base, d;
    base = run_count;
    clear_mon();
    start_run(32'h400, 32'h401, 3, 8'h96, 1);
    cyc = 0;
    while (run_count != base + 16'd3 && cyc < BUDGET) begin
      @(posedge F14M); #1;
      cyc++;
    end
    tests_run++; if (run_count != base + 16'd3 || busy !== 1'b1) begin fails++; $display("FAIL loop_runs got run=%0d busy=%b want %0d/1", run_count - base, busy, 3); end
    abort = 1'b1;
    wait_done(cyc, to);
    abort = 1'b0;
    loop = 1'b0;
    d = run_count - base;
    tests_run++; if (to || !(d == 16'd3 || d == 16'd4)) begin fails++; $display("FAIL loop_count got to=%0b runs=%0d want 3 or 4", to, d); end
    tests_run++; if ({done, pass, busy, led} !== 4'b1001 || err_count !== 16'd0) begin fails++; $display("FAIL loop_status got dpbl=%b err=%0d want 1001/0", {done, pass, busy, led}, err_count); end
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    logic [15:0] base;
    base = run_count;
    corrupt_en = 1'b1;
    corrupt_addr = AW'(32'h2000);
    start_run(32'h2000, 32'h2003, 0, 8'h5A, 1);
    cyc = 0;
    while (run_count == base && cyc < BUDGET) begin @(posedge F14M); #1; cyc++; end
    while (!bus.sdram_oe && cyc < BUDGET) begin @(posedge F14M); #1; cyc++; end
    tests_run++; if (bus.sdram_oe !== 1'b1 || err_count !== 16'd1) begin fails++; $display("FAIL rst_mid_setup got oe=%b err=%0d want 1/1", bus.sdram_oe, err_count); end
    #2 RESET_n = 1'b0;
    #1;
    tests_run++; if ({bus.sdram_oe, bus.sdram_we} !== 2'b00 || bus.sdram_addr !== '0) begin fails++; $display("FAIL rst_mid_bus got oe=%b we=%b a=%h want 0/0/0", bus.sdram_oe, bus.sdram_we, bus.sdram_addr); end
    tests_run++; if ({busy, done, pass, led} !== 4'b0 || {err_count, run_count} !== 32'h0 || fail_addr !== '0 || fail_data !== '0) begin fails++; $display("FAIL rst_mid_status got bdpl=%b err=%0d run=%0d fa=%h fd=%h want 0", {busy, done, pass, led}, err_count, run_count, fail_addr, fail_data); end
    corrupt_en = 1'b0;
    loop = 1'b0;
    @(posedge F14M); #1;
    RESET_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge F14M);
    #1;
    tests_run++; if (wr_a.size() + rd_a.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got strobes=%0d busy=%b done=%b want 0/0/0", wr_a.size() + rd_a.size(), busy, done); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_empty_range();
    test_top_address();
    test_random();
    test_start_while_busy();
    test_loop_abort();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
